// File: rtl/inv_subbytes_seq_if.sv
// -----------------------------------------------------------------------------
// inv_subbytes_seq_if
// Block-level bus for the sequential AES InvSubBytes engine.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready are
// both high. The source holds valid and data stable until that edge; valid
// never depends combinationally on ready. in_ready is a function of engine
// state only.
//
// Signals
//   in_valid   master->slave  in_data carries a 128-bit state block
//   in_ready   slave->master  engine idle, can accept a block
//   in_data    master->slave  byte 0 = [127:120], byte 15 = [7:0]
//   out_valid  slave->master  out_data carries a completed result
//   out_ready  master->slave  downstream accepts out_data
//   out_data   slave->master  InvSbox applied bytewise, same byte order
//   busy       slave->master  engine is working on or holding a block
// -----------------------------------------------------------------------------
interface inv_subbytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/inv_subbytes_seq.sv
// -----------------------------------------------------------------------------
// inv_subbytes_seq
// Sequential AES InvSubBytes: applies the inverse S-box to all 16 bytes of a
// 128-bit state, LANES bytes per cycle, one block in flight.
//
// Parameters
//   LANES        bytes substituted per cycle (1, 2, 4, 8 or 16)
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; drops any block in flight
//   bus          slave side of inv_subbytes_seq_if (in/out handshakes, busy)
//   dbg_state_o  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// -----------------------------------------------------------------------------
module inv_subbytes_seq #(
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inv_subbytes_seq_if.slave    bus,
  output logic [1:0]           dbg_state_o
);

  localparam int GROUPS = 16 / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Inverse S-box, entry 0x00 at the MSB end.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [127:0]   work_q, work_d;
  logic [127:0]   work_sub;
  logic           last_group;

  assign last_group = (cnt_q == CW'(GROUPS - 1));

  // Working register with the current group of LANES bytes substituted.
  // Group 0 covers byte 0 (MSB end), so byte k sits at bits [127-8k -: 8].
  always_comb begin
    work_sub = work_q;
    for (int l = 0; l < LANES; l++) begin
      work_sub[127 - 8 * (int'(cnt_q) * LANES + l) -: 8] =
        inv_sbox(work_q[127 - 8 * (int'(cnt_q) * LANES + l) -: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.in_data;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        work_d = work_sub;
        if (last_group) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        // Result held stable until the downstream handshake completes.
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // All handshake outputs decode state only: no ready-to-ready paths.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_BUSY) || (state_q == S_DONE);
  assign bus.out_data  = work_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
module tb_inv_subbytes_seq;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  inv_subbytes_seq_if bus_m ();
  inv_subbytes_seq_if bus_a1 ();
  inv_subbytes_seq_if bus_a16 ();
  logic [1:0] dbg_m, dbg_a1, dbg_a16;

  inv_subbytes_seq #(.LANES(4))  dut_m   (.clk(clk), .rst_n(rst_n), .bus(bus_m),   .dbg_state_o(dbg_m));
  inv_subbytes_seq #(.LANES(1))  dut_a1  (.clk(clk), .rst_n(rst_n), .bus(bus_a1),  .dbg_state_o(dbg_a1));
  inv_subbytes_seq #(.LANES(16)) dut_a16 (.clk(clk), .rst_n(rst_n), .bus(bus_a16), .dbg_state_o(dbg_a16));

  // ---------------- golden forward S-box (for round-trip vectors) ----------------
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[127 - 8 * i -: 8] = SBOX[2047 - 8 * int'(x[127 - 8 * i -: 8]) -: 8];
    end
    return r;
  endfunction

  // ---------------- vectors ----------------
  localparam logic [127:0] V_SEQ_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] V_SEQ_OUT = 128'h000102030405060708090a0b0c0d0e0f;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_q1[$];
  logic [127:0] exp_q16[$];
  int acc_edge     = 0;
  int aux_acc_edge = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %032h expected %032h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Main monitor: latency on rising out_valid, data on each handshake.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (bus_m.out_valid && !prev_ov)
        check("lat_l4", 128'(cyc - acc_edge), 128'd4);
      if (bus_m.out_valid && bus_m.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_l4", bus_m.out_data, 128'hx);
        end else begin
          check("data_l4", bus_m.out_data, exp_q.pop_front());
        end
      end
      prev_ov = bus_m.out_valid;
    end
  end

  // Auxiliary monitors: out_ready is held high, so handshake = first appearance.
  always @(negedge clk) begin
    if (rst_n && bus_a1.out_valid && bus_a1.out_ready) begin
      check("lat_l1", 128'(cyc - aux_acc_edge), 128'd16);
      if (exp_q1.size() == 0) check("unexpected_l1", bus_a1.out_data, 128'hx);
      else                    check("data_l1", bus_a1.out_data, exp_q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus_a16.out_valid && bus_a16.out_ready) begin
      check("lat_l16", 128'(cyc - aux_acc_edge), 128'd1);
      if (exp_q16.size() == 0) check("unexpected_l16", bus_a16.out_data, 128'hx);
      else                     check("data_l16", bus_a16.out_data, exp_q16.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Entered #1 after a rising edge; leaves in_valid high so callers can chain.
  task automatic send(input logic [127:0] d, input logic [127:0] e);
    int tries;
    tries = 0;
    bus_m.in_valid = 1'b1;
    bus_m.in_data  = d;
    @(negedge clk);
    while (!bus_m.in_ready && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    if (!bus_m.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", tries);
    end else begin
      exp_q.push_back(e);
      acc_edge = cyc + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain_m();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_l4", 128'(exp_q.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_aux(input logic [127:0] d, input logic [127:0] e);
    int t;
    bus_a1.in_valid  = 1'b1;
    bus_a1.in_data   = d;
    bus_a16.in_valid = 1'b1;
    bus_a16.in_data  = d;
    @(negedge clk);
    check("aux_ready_l1",  128'(bus_a1.in_ready),  128'd1);
    check("aux_ready_l16", 128'(bus_a16.in_ready), 128'd1);
    exp_q1.push_back(e);
    exp_q16.push_back(e);
    aux_acc_edge = cyc + 1;
    @(posedge clk);
    #1;
    bus_a1.in_valid  = 1'b0;
    bus_a16.in_valid = 1'b0;
    t = 0;
    while ((exp_q1.size() != 0 || exp_q16.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_aux", 128'(exp_q1.size() + exp_q16.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] orig;
    int t;

    bus_m.in_valid    = 1'b0;
    bus_m.in_data     = '0;
    bus_m.out_ready   = 1'b1;
    bus_a1.in_valid   = 1'b0;
    bus_a1.in_data    = '0;
    bus_a1.out_ready  = 1'b1;
    bus_a16.in_valid  = 1'b0;
    bus_a16.in_data   = '0;
    bus_a16.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  128'(bus_m.in_ready),  128'd1);
    check("rst_out_valid", 128'(bus_m.out_valid), 128'd0);
    check("rst_busy",      128'(bus_m.busy),      128'd0);
    check("rst_state",     128'(dbg_m),           128'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of BUSY drops the block.
    send(V_SEQ_IN, V_SEQ_OUT);
    bus_m.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_busy", 128'(bus_m.busy), 128'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_out_valid", 128'(bus_m.out_valid), 128'd0);
    check("midrst_busy",      128'(bus_m.busy),      128'd0);
    check("midrst_state",     128'(dbg_m),           128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", 128'(bus_m.in_ready), 128'd1);
    @(posedge clk);
    #1;

    // Known vector, then uniform-byte boundary vectors chained.
    send(V_SEQ_IN, V_SEQ_OUT);
    bus_m.in_valid = 1'b0;
    drain_m();
    send({16{8'h00}}, {16{8'h52}});
    send({16{8'hff}}, {16{8'h7d}});
    send({16{8'h16}}, {16{8'hff}});
    bus_m.in_valid = 1'b0;
    drain_m();

    // Backpressure in DONE; in_valid with other data is ignored meanwhile.
    bus_m.out_ready = 1'b0;
    send(V_SEQ_IN, V_SEQ_OUT);
    bus_m.in_valid = 1'b1;
    bus_m.in_data  = {16{8'h00}};
    t = 0;
    while (!bus_m.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(bus_m.out_valid), 128'd1);
      check("bp_out_data",  bus_m.out_data,        V_SEQ_OUT);
      check("bp_in_ready",  128'(bus_m.in_ready),  128'd0);
    end
    @(posedge clk);
    #1;
    bus_m.in_valid  = 1'b0;
    bus_m.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready",  128'(bus_m.in_ready),  128'd1);
    check("bp_release_out_valid", 128'(bus_m.out_valid), 128'd0);
    @(posedge clk);
    #1;

    // Back-to-back round trips: feed SubBytes(orig), expect orig.
    for (int k = 0; k < 3; k++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      send(sub_bytes(orig), orig);
    end
    bus_m.in_valid = 1'b0;
    drain_m();

    // Latency and data at LANES=1 and LANES=16.
    send_aux(V_SEQ_IN, V_SEQ_OUT);
    send_aux({16{8'hff}}, {16{8'h7d}});

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
